// File: rtl/phy_rx_deserializer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_deserializer_pkg
// Brief    : Shared PHY symbol constants, FSM encoding and lane helpers.
// Revision : 1.0 - initial release
// ============================================================================
package phy_rx_deserializer_pkg;

    localparam int         c_WIDTH      = 8;
    localparam logic [7:0] c_BC_SYM     = 8'hBC;
    localparam logic [7:0] c_IDLE_SYM   = c_BC_SYM;
    localparam int         c_LOCK_COUNT = 4;
    localparam int         c_NUM_LANES  = 4;

    typedef logic [1:0] rx_state_t;
    typedef logic [1:0] lane_idx_t;

    localparam rx_state_t c_ST_SEARCH = 2'd0;
    localparam rx_state_t c_ST_ALIGN  = 2'd1;
    localparam rx_state_t c_ST_ACTIVE = 2'd2;

    localparam lane_idx_t c_LAST_LANE = 2'd3;

    // Round-robin lane order matches the TX TDM mux: 0,1,2,3,0,...
    function automatic lane_idx_t next_lane(input lane_idx_t lane);
        return lane + 2'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/phy_rx_deserializer_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_deserializer_if
// Brief    : Serial input and 4-lane deserialized output bus of the RX PHY.
// Revision : 1.0 - initial release
// ============================================================================
interface phy_rx_deserializer_if
    import phy_rx_deserializer_pkg::*;
#(
    parameter int WIDTH = c_WIDTH
);

    logic             data_in;
    logic [WIDTH-1:0] byte_out;
    logic             byte_valid;
    logic [WIDTH-1:0] data_out0;
    logic [WIDTH-1:0] data_out1;
    logic [WIDTH-1:0] data_out2;
    logic [WIDTH-1:0] data_out3;
    logic             valid_out0;
    logic             valid_out1;
    logic             valid_out2;
    logic             valid_out3;
    logic             frame_strobe;
    logic             active;
    logic             idle_out;

    modport master (
        input  data_in,
        output byte_out, byte_valid,
        output data_out0, data_out1, data_out2, data_out3,
        output valid_out0, valid_out1, valid_out2, valid_out3,
        output frame_strobe, active, idle_out
    );

    modport slave (
        output data_in,
        input  byte_out, byte_valid,
        input  data_out0, data_out1, data_out2, data_out3,
        input  valid_out0, valid_out1, valid_out2, valid_out3,
        input  frame_strobe, active, idle_out
    );

endinterface
`default_nettype wire

// File: rtl/phy_rx_deserializer_rx_shift_align.sv
`default_nettype none
// ============================================================================
// Module   : rx_shift_align
// Brief    : Serial shift register, BC-symbol byte alignment and lock FSM.
// Revision : 1.0 - initial release
// ============================================================================
module rx_shift_align
    import phy_rx_deserializer_pkg::*;
#(
    parameter int               WIDTH      = c_WIDTH,
    parameter logic [WIDTH-1:0] BC_SYM     = WIDTH'(c_BC_SYM),
    parameter int               LOCK_COUNT = c_LOCK_COUNT
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             data_in,
    output logic [WIDTH-1:0] sym,
    output logic             sym_stb,
    output logic             active
);

    localparam int c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_BCC_W = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;

    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_BIT_ONE  = c_CNT_W'(1);
    localparam logic [c_BCC_W-1:0] c_BCC_ONE  = c_BCC_W'(1);
    localparam logic [c_BCC_W-1:0] c_LOCK_CNT = c_BCC_W'(LOCK_COUNT);

    rx_state_t          r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic [c_BCC_W-1:0] r_bc_cnt;
    logic [WIDTH-1:0]   r_sym;
    logic               r_sym_stb;
    logic               r_active;

    logic [WIDTH-1:0]   w_shift_nxt;
    logic               w_is_bc;
    logic               w_boundary;
    logic [c_BCC_W-1:0] w_bc_cnt_inc;

    // The window includes the bit sampled on this edge, so a match marks
    // the edge on which the last bit of the symbol arrives.
    assign w_shift_nxt  = {r_shift[WIDTH-2:0], data_in};
    assign w_is_bc      = (w_shift_nxt == BC_SYM);
    assign w_boundary   = (r_bit_cnt == c_LAST_BIT);
    assign w_bc_cnt_inc = r_bc_cnt + c_BCC_ONE;

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_SEARCH;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_bc_cnt  <= '0;
            r_sym     <= '0;
            r_sym_stb <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_shift   <= w_shift_nxt;
            r_sym_stb <= 1'b0;
            r_bit_cnt <= w_boundary ? '0 : (r_bit_cnt + c_BIT_ONE);

            case (r_state)
                c_ST_SEARCH: begin
                    if (w_is_bc) begin
                        r_bit_cnt <= '0;
                        r_bc_cnt  <= c_BCC_ONE;
                        if (c_BCC_ONE == c_LOCK_CNT) begin
                            r_state  <= c_ST_ACTIVE;
                            r_active <= 1'b1;
                        end else begin
                            r_state  <= c_ST_ALIGN;
                        end
                    end
                end
                c_ST_ALIGN: begin
                    if (w_boundary) begin
                        if (w_is_bc) begin
                            r_bc_cnt <= w_bc_cnt_inc;
                            if (w_bc_cnt_inc == c_LOCK_CNT) begin
                                r_state  <= c_ST_ACTIVE;
                                r_active <= 1'b1;
                            end
                        end else begin
                            r_state  <= c_ST_SEARCH;
                            r_bc_cnt <= '0;
                        end
                    end
                end
                c_ST_ACTIVE: begin
                    // Alignment is frozen: only boundary windows are forwarded.
                    if (w_boundary) begin
                        r_sym     <= w_shift_nxt;
                        r_sym_stb <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_SEARCH;
                end
            endcase
        end
    end

    assign sym     = r_sym;
    assign sym_stb = r_sym_stb;
    assign active  = r_active;

endmodule
`default_nettype wire

// File: rtl/phy_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : phy_rx_deserializer
// Brief    : RX PHY: aligned symbols classified and demuxed onto 4 byte lanes.
// Revision : 1.0 - initial release
// ============================================================================
module phy_rx_deserializer
    import phy_rx_deserializer_pkg::*;
#(
    parameter int               WIDTH      = c_WIDTH,
    parameter logic [WIDTH-1:0] BC_SYM     = WIDTH'(c_BC_SYM),
    parameter int               LOCK_COUNT = c_LOCK_COUNT
) (
    input  logic                  clk_32f,
    input  logic                  reset,
    phy_rx_deserializer_if.master bus
);

    logic [WIDTH-1:0] w_sym;
    logic             w_sym_stb;
    logic             w_lock;
    logic             w_is_data;

    logic [WIDTH-1:0] r_byte;
    logic             r_byte_valid;
    logic             r_idle;
    logic             r_frame_strobe;
    logic             r_active;
    lane_idx_t        r_lane_ptr;

    rx_shift_align #(
        .WIDTH      (WIDTH),
        .BC_SYM     (BC_SYM),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_shift_align (
        .clk_32f (clk_32f),
        .reset   (reset),
        .data_in (bus.data_in),
        .sym     (w_sym),
        .sym_stb (w_sym_stb),
        .active  (w_lock)
    );

    assign w_is_data = (w_sym != BC_SYM);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_byte         <= '0;
            r_byte_valid   <= 1'b0;
            r_idle         <= 1'b0;
            r_frame_strobe <= 1'b0;
            r_active       <= 1'b0;
            r_lane_ptr     <= '0;
        end else begin
            r_active       <= w_lock;
            r_byte_valid   <= 1'b0;
            r_frame_strobe <= 1'b0;
            if (!w_lock) begin
                r_lane_ptr <= '0;
            end else if (w_sym_stb) begin
                // BC symbols still consume a slot so lanes stay in TX mux order.
                r_byte         <= w_sym;
                r_byte_valid   <= w_is_data;
                r_idle         <= !w_is_data;
                r_frame_strobe <= (r_lane_ptr == c_LAST_LANE);
                r_lane_ptr     <= next_lane(r_lane_ptr);
            end
        end
    end

    for (genvar i = 0; i < c_NUM_LANES; i++) begin : g_lane
        logic [WIDTH-1:0] r_data;
        logic             r_valid;

        always_ff @(posedge clk_32f or negedge reset) begin
            if (!reset) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_sym_stb && (r_lane_ptr == lane_idx_t'(i))) begin
                r_valid <= w_is_data;
                if (w_is_data) begin
                    r_data <= w_sym;
                end
            end
        end
    end

    assign bus.byte_out     = r_byte;
    assign bus.byte_valid   = r_byte_valid;
    assign bus.idle_out     = r_idle;
    assign bus.frame_strobe = r_frame_strobe;
    assign bus.active       = r_active;
    assign bus.data_out0    = g_lane[0].r_data;
    assign bus.data_out1    = g_lane[1].r_data;
    assign bus.data_out2    = g_lane[2].r_data;
    assign bus.data_out3    = g_lane[3].r_data;
    assign bus.valid_out0   = g_lane[0].r_valid;
    assign bus.valid_out1   = g_lane[1].r_valid;
    assign bus.valid_out2   = g_lane[2].r_valid;
    assign bus.valid_out3   = g_lane[3].r_valid;

endmodule
`default_nettype wire
